// File: rtl/fighter_fsm.sv
// Per-player move/attack sequencer: action state, sprite x and hitbox arming, stepped once per frame_tick.
// Latency: state/sprite_x/hit_armed update on the edge ending a frame_tick cycle; stable for the whole frame.
// Backpressure: none; button/hit pulses on non-tick cycles are latched as pending and applied at the next tick.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   btn_left/right    walk buttons (level, synchronised)
//   btn_attack        attack button (level; rising edge = press)
//   opp_x             opponent sprite_x, used for the no-overlap clamp
//   hit_in            pulse: our hurtbox was struck
//   hit_landed        pulse: our hitbox connected
//   state             action state (0 idle,1 fwd,2 back,3 startup,4 active,5 recovery,6 hitstun,7 blockstun)
//   sprite_x          sprite left edge
//   hit_armed         hitbox may still score in the current active window
//
// Optional feature: define FIGHTER_BLOCK_EN to turn hits taken while idle/walking back with back held
// into blockstun (half pushback). Without it, every hit produces hitstun and state 7 never occurs.
module fighter_fsm #(
  parameter bit IS_MIRRORED      = 1'b0,
  parameter int START_X          = 100,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 576,
  parameter int WALK_SPEED       = 2,
  parameter int PUSHBACK         = 8,
  parameter int STARTUP_FRAMES   = 5,
  parameter int ACTIVE_FRAMES    = 3,
  parameter int RECOVERY_FRAMES  = 12,
  parameter int HITSTUN_FRAMES   = 20,
  parameter int BLOCKSTUN_FRAMES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic [9:0] opp_x,
  input  logic       hit_in,
  input  logic       hit_landed,
  output logic [2:0] state,
  output logic [9:0] sprite_x,
  output logic       hit_armed
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WALK_FWD  = 3'd1,
    S_WALK_BACK = 3'd2,
    S_STARTUP   = 3'd3,
    S_ACTIVE    = 3'd4,
    S_RECOVERY  = 3'd5,
    S_HITSTUN   = 3'd6,
    S_BLOCKSTUN = 3'd7
  } state_t;

  localparam logic signed [10:0] XMIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] WALK_S  = 11'(WALK_SPEED);
  localparam logic signed [10:0] PUSH_S  = 11'(PUSHBACK);
  localparam logic signed [10:0] BPUSH_S = 11'(PUSHBACK / 2);
  localparam logic signed [10:0] WIDTH_S = 11'sd64;

  localparam logic [4:0] STARTUP_LD = 5'(STARTUP_FRAMES - 1);
  localparam logic [4:0] ACTIVE_LD  = 5'(ACTIVE_FRAMES - 1);
  localparam logic [4:0] RECOV_LD   = 5'(RECOVERY_FRAMES - 1);
  localparam logic [4:0] HIT_LD     = 5'(HITSTUN_FRAMES - 1);
  localparam logic [4:0] BLOCK_LD   = 5'(BLOCKSTUN_FRAMES - 1);

  state_t     st;
  logic [4:0] phase_cnt;
  logic       attack_pend;
  logic       hit_pend;
  logic       btn_attack_q;

  assign state = st;

  logic fwd_btn, back_btn;
  assign fwd_btn  = IS_MIRRORED ? btn_left  : btn_right;
  assign back_btn = IS_MIRRORED ? btn_right : btn_left;

  logic in_neutral, in_stun, attack_rise, attack_now, hit_now, block_now;
  assign in_neutral  = (st == S_IDLE) || (st == S_WALK_FWD) || (st == S_WALK_BACK);
  assign in_stun     = (st == S_HITSTUN) || (st == S_BLOCKSTUN);
  assign attack_rise = btn_attack & ~btn_attack_q;
  // Same-cycle press/hit count for the tick they coincide with.
  assign attack_now  = attack_pend | (attack_rise & in_neutral);
  assign hit_now     = hit_pend | (hit_in & ~in_stun);

`ifdef FIGHTER_BLOCK_EN
  assign block_now = ((st == S_IDLE) || (st == S_WALK_BACK)) && back_btn;
`else
  assign block_now = 1'b0;
`endif

  function automatic logic signed [10:0] clamp_arena(input logic signed [10:0] v);
    logic signed [10:0] r;
    r = v;
    if (r < XMIN_S)      r = XMIN_S;
    else if (r > XMAX_S) r = XMAX_S;
    return r;
  endfunction

  // Candidate positions, all in 11-bit signed so underflow below X_MIN is visible.
  logic signed [10:0] x_s, opp_s, lim_s;
  logic signed [10:0] x_fwd, x_back, x_push, x_block;

  always_comb begin
    x_s   = signed'({1'b0, sprite_x});
    opp_s = signed'({1'b0, opp_x});
    lim_s = IS_MIRRORED ? (opp_s + WIDTH_S) : (opp_s - WIDTH_S);

    x_fwd   = clamp_arena(IS_MIRRORED ? (x_s - WALK_S)  : (x_s + WALK_S));
    x_back  = clamp_arena(IS_MIRRORED ? (x_s + WALK_S)  : (x_s - WALK_S));
    x_push  = clamp_arena(IS_MIRRORED ? (x_s + PUSH_S)  : (x_s - PUSH_S));
    x_block = clamp_arena(IS_MIRRORED ? (x_s + BPUSH_S) : (x_s - BPUSH_S));

    // No-overlap clamp on forward moves only; if already inside the limit, hold
    // rather than being shoved backward.
    if (!IS_MIRRORED) begin
      if (x_fwd > lim_s) x_fwd = (x_s > lim_s) ? x_s : lim_s;
    end else begin
      if (x_fwd < lim_s) x_fwd = (x_s < lim_s) ? x_s : lim_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      sprite_x     <= 10'(START_X);
      hit_armed    <= 1'b0;
      phase_cnt    <= 5'd0;
      attack_pend  <= 1'b0;
      hit_pend     <= 1'b0;
      btn_attack_q <= 1'b0;
    end else begin
      btn_attack_q <= btn_attack;

      // Presses during attack/stun phases are dropped, not queued.
      if (attack_rise && in_neutral) attack_pend <= 1'b1;
      if (hit_in && !in_stun)        hit_pend    <= 1'b1;
      if (hit_landed)                hit_armed   <= 1'b0;

      if (frame_tick) begin
        if (hit_now) begin
          hit_pend    <= 1'b0;
          attack_pend <= 1'b0;
          hit_armed   <= 1'b0;
          if (block_now) begin
            st        <= S_BLOCKSTUN;
            phase_cnt <= BLOCK_LD;
            sprite_x  <= x_block[9:0];
          end else begin
            st        <= S_HITSTUN;
            phase_cnt <= HIT_LD;
            sprite_x  <= x_push[9:0];
          end
        end else if (!in_neutral) begin
          if (phase_cnt != 5'd0) begin
            phase_cnt <= phase_cnt - 5'd1;
          end else begin
            case (st)
              S_STARTUP: begin
                st        <= S_ACTIVE;
                phase_cnt <= ACTIVE_LD;
                hit_armed <= 1'b1;
              end
              S_ACTIVE: begin
                st        <= S_RECOVERY;
                phase_cnt <= RECOV_LD;
                hit_armed <= 1'b0;
              end
              default: st <= S_IDLE;
            endcase
          end
        end else if (attack_now) begin
          st          <= S_STARTUP;
          phase_cnt   <= STARTUP_LD;
          attack_pend <= 1'b0;
        end else if (fwd_btn && !back_btn) begin
          st       <= S_WALK_FWD;
          sprite_x <= x_fwd[9:0];
        end else if (back_btn && !fwd_btn) begin
          st       <= S_WALK_BACK;
          sprite_x <= x_back[9:0];
        end else begin
          st <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fighter_fsm.sv
// Directed bench for fighter_fsm (IS_MIRRORED=0, default parameters).
// Inputs change on negedges; outputs are checked on negedges after the tick edge.
// Block-enabled builds expect blockstun where the default build expects hitstun.
module tb_fighter_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_attack;
  logic [9:0] opp_x;
  logic       hit_in, hit_landed;
  logic [2:0] state;
  logic [9:0] sprite_x;
  logic       hit_armed;

  int vectors = 0;
  int errors  = 0;

`ifdef FIGHTER_BLOCK_EN
  localparam bit BLOCK = 1'b1;
`else
  localparam bit BLOCK = 1'b0;
`endif

  fighter_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .opp_x      (opp_x),
    .hit_in     (hit_in),
    .hit_landed (hit_landed),
    .state      (state),
    .sprite_x   (sprite_x),
    .hit_armed  (hit_armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One frame: tick pulse plus an idle cycle; single-cycle pulses are dropped afterwards.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hit_in     = 1'b0;
    hit_landed = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] stun_st;
    int         stun_n;
    int         exp_x;
    logic [2:0] exp_s;

    rst = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
    opp_x = 10'd400; hit_in = 1'b0; hit_landed = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_x",     16'(sprite_x), 16'd100);
    chk("rst_armed", 16'(hit_armed), 16'd0);

    // Walk forward 10 frames then release.
    btn_right = 1'b1;
    repeat (10) tick();
    chk("walk_state", 16'(state), 16'd1);
    chk("walk_x",     16'(sprite_x), 16'd120);
    btn_right = 1'b0;
    tick();
    chk("release_state", 16'(state), 16'd0);
    chk("release_x",     16'(sprite_x), 16'd120);

    // Full attack: 5 startup, 3 active, 12 recovery, then idle.
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    chk("atk_t1", 16'(state), 16'd3);
    for (int i = 2; i <= 21; i++) begin
      tick();
      exp_s = (i <= 5) ? 3'd3 : (i <= 8) ? 3'd4 : (i <= 20) ? 3'd5 : 3'd0;
      chk($sformatf("atk_t%0d", i), 16'(state), 16'(exp_s));
      if (i == 6 || i == 8) chk($sformatf("atk_armed_t%0d", i), 16'(hit_armed), 16'd1);
      if (i == 9)           chk("atk_disarm", 16'(hit_armed), 16'd0);
    end

    // hit_landed during the second active frame disarms at once.
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    repeat (6) tick();
    chk("hl_pre_state", 16'(state), 16'd4);
    chk("hl_pre_armed", 16'(hit_armed), 16'd1);
    hit_landed = 1'b1;
    cyc();
    hit_landed = 1'b0;
    chk("hl_armed", 16'(hit_armed), 16'd0);
    chk("hl_state", 16'(state), 16'd4);
    tick();
    chk("hl_act3", 16'(state), 16'd4);
    tick();
    chk("hl_recov", 16'(state), 16'd5);
    repeat (12) tick();
    chk("hl_idle", 16'(state), 16'd0);

    // Approach the opponent and stop at opp_x-64.
    opp_x = 10'd500;
    btn_right = 1'b1;
    repeat (105) tick();
    chk("approach_x", 16'(sprite_x), 16'd330);
    opp_x = 10'd400;
    repeat (5) tick();
    chk("clamp_x",     16'(sprite_x), 16'd336);
    chk("clamp_state", 16'(state), 16'd1);
    opp_x = 10'd300;
    tick();
    chk("closer_hold_x", 16'(sprite_x), 16'd336);
    btn_right = 1'b0;

    // Walk back to 200.
    btn_left = 1'b1;
    repeat (68) tick();
    chk("back_x",     16'(sprite_x), 16'd200);
    chk("back_state", 16'(state), 16'd2);
    btn_left = 1'b0;

    // Hit landed on us during startup (pulse between ticks).
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    tick();
    chk("su_state", 16'(state), 16'd3);
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    chk("su_pend_state", 16'(state), 16'd3);
    tick();
    chk("hs_state", 16'(state), 16'd6);
    chk("hs_x",     16'(sprite_x), 16'd192);
    btn_attack = 1'b1;
    cyc();
    cyc();
    btn_attack = 1'b0;
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    repeat (19) tick();
    chk("hs_last", 16'(state), 16'd6);
    tick();
    chk("hs_end", 16'(state), 16'd0);
    chk("hs_end_x", 16'(sprite_x), 16'd192);
    tick();
    chk("hs_no_atk", 16'(state), 16'd0);

    // Hit arriving on the tick where the active phase expires: hit wins.
    btn_attack = 1'b1;
    tick();
    btn_attack = 1'b0;
    repeat (7) tick();
    chk("exp_pre_state", 16'(state), 16'd4);
    chk("exp_pre_armed", 16'(hit_armed), 16'd1);
    hit_in = 1'b1;
    tick();
    chk("exp_state", 16'(state), 16'd6);
    chk("exp_x",     16'(sprite_x), 16'd184);
    chk("exp_armed", 16'(hit_armed), 16'd0);
    repeat (19) tick();
    chk("exp_last", 16'(state), 16'd6);
    tick();
    chk("exp_end", 16'(state), 16'd0);

    // Hit while holding back: blockstun when enabled, hitstun otherwise.
    stun_st = BLOCK ? 3'd7 : 3'd6;
    stun_n  = BLOCK ? 10 : 20;
    exp_x   = BLOCK ? 180 : 176;
    btn_left = 1'b1;
    hit_in = 1'b1;
    tick();
    btn_left = 1'b0;
    chk("blk_state", 16'(state), 16'(stun_st));
    chk("blk_x",     16'(sprite_x), 16'(exp_x));
    repeat (stun_n - 1) tick();
    chk("blk_last", 16'(state), 16'(stun_st));
    tick();
    chk("blk_end", 16'(state), 16'd0);

    // Walk back into X_MIN and stay there; pushback also clamps.
    btn_left = 1'b1;
    repeat (95) tick();
    chk("xmin_x",     16'(sprite_x), 16'd0);
    chk("xmin_state", 16'(state), 16'd2);
    hit_in = 1'b1;
    tick();
    chk("xmin_hit_x",     16'(sprite_x), 16'd0);
    chk("xmin_hit_state", 16'(state), 16'(stun_st));
    btn_left = 1'b0;

    // Reset mid-stun aborts immediately.
    tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_state", 16'(state), 16'd0);
    chk("rst2_x",     16'(sprite_x), 16'd100);
    chk("rst2_armed", 16'(hit_armed), 16'd0);
    tick();
    chk("rst2_tick_state", 16'(state), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
